// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential binary-to-BCD converter.
//   state_e        : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W    : bits per BCD digit
//   BCD_ADJ_THRESH : digit value at or above which the add-3 correction applies
//   BCD_ADJ_ADD    : correction added to a digit before each shift
package bcd_pkg;
   localparam int BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD = 4'd3;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble correction cell, adds 3 to a BCD digit that is >= 5.
//   digit_i : scratch BCD digit before the shift
//   digit_o : corrected digit; never carries into the neighbouring digit
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BCD_DIGIT_W-1:0] digit_o
);
   assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + BCD_ADJ_ADD : digit_i;
endmodule

// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: multi-cycle double-dabble binary-to-BCD converter, one input bit per clock.
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset; aborts any conversion in flight
//   start    : conversion request, sampled only while idle
//   bin_in   : binary operand, captured on the accepted start cycle
//   busy     : high while a conversion is in progress
//   done     : one-cycle pulse coincident with the result outputs updating
//   bcd_out  : packed BCD result, ones digit in [3:0]
//   sign_out : operand was negative (SIGNED builds only)
//   overflow : magnitude did not fit in DIGITS digits; bcd_out keeps the low digits
module seq_bin2bcd
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 9,
   parameter int DIGITS = 3,
   parameter bit SIGNED = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [BIN_W-1:0]              bin_in,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
   output logic                          sign_out,
   output logic                          overflow
);
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = BCD_DIGIT_W * DIGITS;

   state_e           state_q, state_d;
   logic [BIN_W-1:0] shift_q, shift_d;
   logic [BCD_W-1:0] scratch_q, scratch_d, scratch_adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sign_lat_q, sign_lat_d;
   logic             ovf_st_q, ovf_st_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic             sign_q, sign_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic             neg;
   logic [BIN_W-1:0] mag;

   // Two's-complement negation read as unsigned gives the right magnitude even for the most-negative value.
   assign neg = SIGNED && bin_in[BIN_W-1];
   assign mag = neg ? -bin_in : bin_in;

   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i(scratch_q[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_o(scratch_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      sign_lat_d = sign_lat_q;
      ovf_st_d   = ovf_st_q;
      bcd_d      = bcd_q;
      sign_d     = sign_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      unique case (state_q)
         IDLE: if (start) begin
            shift_d    = mag;
            sign_lat_d = neg;
            scratch_d  = '0;
            ovf_st_d   = 1'b0;
            cnt_d      = CNT_W'(BIN_W);
            state_d    = SHIFT;
         end
         SHIFT: begin
            // Corrected scratch and operand shift together; the top scratch bit falls off.
            {scratch_d, shift_d} = {scratch_adj[BCD_W-2:0], shift_q, 1'b0};
            ovf_st_d = ovf_st_q | scratch_adj[BCD_W-1];
            cnt_d    = cnt_q - CNT_W'(1);
            state_d  = (cnt_q == CNT_W'(1)) ? DONE : SHIFT;
         end
         DONE: begin
            bcd_d   = scratch_q;
            sign_d  = sign_lat_q;
            ovf_d   = ovf_st_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         sign_lat_q <= 1'b0;
         ovf_st_q   <= 1'b0;
         bcd_q      <= '0;
         sign_q     <= 1'b0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         sign_lat_q <= sign_lat_d;
         ovf_st_q   <= ovf_st_d;
         bcd_q      <= bcd_d;
         sign_q     <= sign_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign sign_out = sign_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_seq_bin2bcd.sv
// tb_seq_bin2bcd: randomized self-checking bench for three seq_bin2bcd configurations.
module tb_seq_bin2bcd;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  start_v;
   logic [8:0]  bin0, bin2;
   logic [9:0]  bin1;
   logic [2:0]  busy_w, done_w, sign_w, ovf_w;
   logic [11:0] bcd_w [3];
   int n_chk = 0;
   int n_fail = 0;

   seq_bin2bcd #(.BIN_W(9), .DIGITS(3), .SIGNED(1'b0)) u_d9 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bin_in(bin0), .busy(busy_w[0]),
      .done(done_w[0]), .bcd_out(bcd_w[0]), .sign_out(sign_w[0]), .overflow(ovf_w[0]));
   seq_bin2bcd #(.BIN_W(10), .DIGITS(3), .SIGNED(1'b0)) u_d10 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bin_in(bin1), .busy(busy_w[1]),
      .done(done_w[1]), .bcd_out(bcd_w[1]), .sign_out(sign_w[1]), .overflow(ovf_w[1]));
   seq_bin2bcd #(.BIN_W(9), .DIGITS(3), .SIGNED(1'b1)) u_s9 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bin_in(bin2), .busy(busy_w[2]),
      .done(done_w[2]), .bcd_out(bcd_w[2]), .sign_out(sign_w[2]), .overflow(ovf_w[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Decimal arithmetic reference: magnitude, sign, overflow and low three decimal digits.
   function automatic void model(input int idx, input int unsigned v,
                                 output logic [11:0] bcd, output logic s, output logic o);
      int unsigned w, m;
      w = (idx == 1) ? 10 : 9;
      m = v % (32'd1 << w);
      s = (idx == 2) && (m >= (32'd1 << (w - 1)));
      if (s) m = (32'd1 << w) - m;
      o = (m >= 1000);
      m = m % 1000;
      bcd = 12'(((m / 100) << 8) | (((m / 10) % 10) << 4) | (m % 10));
   endfunction

   task automatic drive(input int idx, input int unsigned v);
      if (idx == 0) bin0 = 9'(v);
      else if (idx == 1) bin1 = 10'(v);
      else bin2 = 9'(v);
   endtask

   task automatic convert(input int idx, input int unsigned v, input bit noisy);
      logic [11:0] e_bcd;
      logic e_s, e_o;
      int w, lat, busy_n;
      bit seen;
      w = (idx == 1) ? 10 : 9;
      model(idx, v, e_bcd, e_s, e_o);
      @(negedge clk);
      drive(idx, v);
      start_v[idx] = 1'b1;
      @(negedge clk);
      start_v[idx] = 1'b0;
      lat = 0;
      busy_n = 0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (k > 0) @(negedge clk);
         if (done_w[idx]) begin
            seen = 1'b1;
            lat = k;
         end else begin
            busy_n += busy_w[idx] ? 1 : 0;
            if (noisy) begin
               start_v[idx] = 1'b1;
               drive(idx, $urandom);
            end
         end
      end
      start_v[idx] = 1'b0;
      check("done_seen", 32'(seen), 32'd1);
      check("latency", lat, w + 1);
      check("busy_cycles", busy_n, w + 1);
      check("bcd_out", 32'(bcd_w[idx]), 32'(e_bcd));
      check("sign_out", 32'(sign_w[idx]), 32'(e_s));
      check("overflow", 32'(ovf_w[idx]), 32'(e_o));
      @(negedge clk);
      check("done_one_cycle", 32'(done_w[idx]), 32'd0);
      check("idle_after", 32'(busy_w[idx]), 32'd0);
   endtask

   task automatic check_zero(input int idx);
      check("rst_busy", 32'(busy_w[idx]), 32'd0);
      check("rst_done", 32'(done_w[idx]), 32'd0);
      check("rst_bcd", 32'(bcd_w[idx]), 32'd0);
      check("rst_sign", 32'(sign_w[idx]), 32'd0);
      check("rst_ovf", 32'(ovf_w[idx]), 32'd0);
   endtask

   initial begin
      int dn;
      rst_n = 1'b0;
      start_v = '0;
      bin0 = '0;
      bin1 = '0;
      bin2 = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) check_zero(i);
      rst_n = 1'b1;

      convert(0, 255, 1'b0);
      convert(0, 0, 1'b0);
      convert(0, 511, 1'b0);
      convert(1, 1023, 1'b0);
      convert(1, 999, 1'b0);
      convert(2, 'h100, 1'b0);
      convert(2, 'h1FF, 1'b0);
      convert(2, 0, 1'b0);
      convert(0, 377, 1'b1);

      convert(0, 123, 1'b0);
      drive(0, $urandom);
      repeat (5) @(negedge clk);
      check("hold_bcd", 32'(bcd_w[0]), 32'h123);

      @(negedge clk);
      bin0 = 9'd300;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_zero(0);
      dn = 0;
      repeat (15) begin
         @(negedge clk);
         dn += done_w[0] ? 1 : 0;
      end
      check("abort_no_done", dn, 0);
      convert(0, 42, 1'b0);

      for (int r = 0; r < 15; r++) begin
         for (int i = 0; i < 3; i++)
            convert(i, $urandom_range(0, (i == 1) ? 1023 : 511), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_bin2bcd.md
Name: seq_bin2bcd

Overview:
Multi-cycle, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one input bit per clock. It generalises the existing combinational 9-bit/3-digit converter to arbitrary binary width and digit count. It adds an optional two's-complement signed mode, a start/busy/done handshake and overflow detection. It sits between arithmetic datapaths and the seven-segment/display drivers, where a small, slow, low-area conversion is preferred over a deep combinational chain.

Parameters:
BIN_W, 9, width of the binary input in bits (>= 2)
DIGITS, 3, number of BCD output digits (>= 1)
SIGNED, 0, 1 = bin_in is two's complement; magnitude is converted and sign reported separately

Ports:
clk  input  1  system clock; one clock domain; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  request a conversion of bin_in; sampled only in IDLE
bin_in  input  BIN_W  binary operand; captured on the accepted start cycle only
busy  output  1  high while a conversion is in progress (state != IDLE)
done  output  1  one-cycle pulse when bcd_out/sign_out/overflow are updated
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (ones) in [3:0]
sign_out  output  1  1 = operand was negative (always 0 when SIGNED=0)
overflow  output  1  1 = magnitude >= 10^DIGITS; bcd_out holds the low DIGITS digits

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE. busy=0, done=0, bcd_out=0, sign_out=0 and overflow=0. Internal shift register, scratch BCD and bit counter cleared. Reset mid-conversion aborts the conversion with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: when start=1, capture the magnitude into the shift register.
  - With SIGNED=1 and bin_in[BIN_W-1]=1, the magnitude is the BIN_W-bit two's-complement negation, read as unsigned. The most-negative value -2^(BIN_W-1) therefore gives 2^(BIN_W-1) correctly.
  - Latch the sign internally, clear scratch BCD and the sticky overflow flag, set bit counter=BIN_W, and go to SHIFT.
- SHIFT, once per cycle:
  - (a) Every scratch digit >= 5 gets +3 (4-bit, no inter-digit carry).
  - (b) {scratch, shift_reg} shifts left by 1; the MSB of shift_reg enters scratch bit 0.
  - (c) If the bit shifted out of scratch[4*DIGITS-1] is 1, set sticky overflow.
  - (d) Decrement the counter; when it reaches 0, go to DONE.
- DONE, exactly one cycle:
  - bcd_out<=scratch, sign_out<=latched sign, overflow<=sticky flag, done=1.
  - Then go to IDLE.
- Latency: start accepted at edge N; done=1 during the cycle after edge N+BIN_W+1. Throughput is one conversion per BIN_W+2 cycles.
- busy=1 in SHIFT and DONE. start is ignored while busy=1, and is not queued.
- bcd_out/sign_out/overflow hold their values between done pulses. They change only in DONE.
- bin_in changes after the start cycle have no effect.
- Zero input yields bcd_out=0 and sign_out=0. Negative zero cannot occur.
- Width rule: the scratch register is exactly 4*DIGITS bits. The add-3 correction never carries between digits.

Decomposition:
- Shared package bcd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - constant BCD_DIGIT_W=4;
  - constant BCD_ADJ_THRESH=5;
  - constant BCD_ADJ_ADD=3.
- One combinational sub-module, bcd_digit_adj: a 4-bit in/out add-3-if->=5 cell, instantiated DIGITS times by generate.
- The counter width is derived as $clog2(BIN_W+1).

Test Plan:
- Defaults, bin_in=255, start pulse -> done 10 cycles after the accepted edge; bcd_out=12'h255, sign_out=0, overflow=0; busy high for 10 cycles.
- Defaults, bin_in=0, then bin_in=511 -> 12'h000, then 12'h511; no overflow.
- BIN_W=10, DIGITS=3, bin_in=1023 -> overflow=1, bcd_out=12'h023. Next conversion of 999 -> overflow=0, 12'h999.
- SIGNED=1, defaults: bin_in=9'h100 (-256) -> sign_out=1, bcd_out=12'h256. bin_in=9'h1FF (-1) -> sign_out=1, 12'h001.
- Start re-asserted and bin_in changed every cycle while busy -> the single result equals the first captured operand, and exactly one done pulse occurs.
- rst_n low for one cycle at SHIFT cycle 4 -> no done pulse; all outputs 0 next cycle. A fresh start of 42 afterwards -> 12'h042.
